// File: rtl/sb_ram40_pkg.sv
// Shared aspect-ratio constants and helpers for the sb_ram40_4k block RAM model.
package sb_ram40_pkg;

  localparam int unsigned MODE_256X16 = 0;
  localparam int unsigned MODE_512X8  = 1;
  localparam int unsigned MODE_1024X4 = 2;
  localparam int unsigned MODE_2048X2 = 3;

  typedef logic [15:0] mem_t [256];

  function automatic int unsigned mode_lane_bits(input int unsigned mode);
    case (mode)
      MODE_512X8:  return 1;
      MODE_1024X4: return 2;
      MODE_2048X2: return 3;
      default:     return 0;
    endcase
  endfunction

  function automatic int unsigned mode_width(input int unsigned mode);
    return 16 >> mode_lane_bits(mode);
  endfunction

endpackage

// File: rtl/sb_ram40_lane_sel.sv
// Address decode for one RAM port: physical word index plus the lane's bit mask and shift.
module sb_ram40_lane_sel
  import sb_ram40_pkg::*;
#(
  parameter int unsigned MODE = MODE_256X16
) (
  input  logic [10:0] addr_i,
  output logic [7:0]  word_o,
  output logic [15:0] lane_mask_o,
  output logic [3:0]  shift_o
);

  localparam int unsigned LANE_BITS = mode_lane_bits(MODE);
  localparam int unsigned WIDTH     = mode_width(MODE);
  localparam logic [2:0]  LANE_MSK  = 3'((1 << LANE_BITS) - 1);
  localparam logic [15:0] SLICE_MSK = 16'((32'd1 << WIDTH) - 1);

  logic [2:0] lane;
  logic       unused_addr;

  // Lane occupies the low address bits; the next 8 bits pick the word, the rest are ignored.
  always_comb begin
    lane        = addr_i[2:0] & LANE_MSK;
    word_o      = addr_i[LANE_BITS +: 8];
    shift_o     = 4'(lane * WIDTH);
    lane_mask_o = SLICE_MSK << shift_o;
  end

  assign unused_addr = ^addr_i;

endmodule

// File: rtl/sb_ram40_4k.sv
// iCE40 4-kbit block RAM model: 256x16 physical store, configurable read/write aspect.
// Define SB_RAM_INIT_EN to preload contents from INIT_0..INIT_F.
module sb_ram40_4k
  import sb_ram40_pkg::*;
#(
  parameter int unsigned  READ_MODE  = 0,
  parameter int unsigned  WRITE_MODE = 0,
  parameter logic [255:0] INIT_0 = '0,
  parameter logic [255:0] INIT_1 = '0,
  parameter logic [255:0] INIT_2 = '0,
  parameter logic [255:0] INIT_3 = '0,
  parameter logic [255:0] INIT_4 = '0,
  parameter logic [255:0] INIT_5 = '0,
  parameter logic [255:0] INIT_6 = '0,
  parameter logic [255:0] INIT_7 = '0,
  parameter logic [255:0] INIT_8 = '0,
  parameter logic [255:0] INIT_9 = '0,
  parameter logic [255:0] INIT_A = '0,
  parameter logic [255:0] INIT_B = '0,
  parameter logic [255:0] INIT_C = '0,
  parameter logic [255:0] INIT_D = '0,
  parameter logic [255:0] INIT_E = '0,
  parameter logic [255:0] INIT_F = '0
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic [10:0] waddr_i,
  input  logic [10:0] raddr_i,
  input  logic [15:0] wdata_i,
  input  logic [15:0] mask_i,
  input  logic        we_i,
  input  logic        wclke_i,
  input  logic        re_i,
  input  logic        rclke_i,
  output logic [15:0] rdata_o
);

`ifdef SB_RAM_INIT_EN
  function automatic mem_t init_contents();
    logic [4095:0] all;
    mem_t          m;
    all = {INIT_F, INIT_E, INIT_D, INIT_C, INIT_B, INIT_A, INIT_9, INIT_8,
           INIT_7, INIT_6, INIT_5, INIT_4, INIT_3, INIT_2, INIT_1, INIT_0};
    for (int unsigned i = 0; i < 256; i++) m[i] = all[16*i +: 16];
    return m;
  endfunction

  mem_t mem_q = init_contents();
`else
  logic unused_init;
  assign unused_init = ^{INIT_F, INIT_E, INIT_D, INIT_C, INIT_B, INIT_A, INIT_9, INIT_8,
                         INIT_7, INIT_6, INIT_5, INIT_4, INIT_3, INIT_2, INIT_1, INIT_0};

  mem_t mem_q = '{default: '0};
`endif

  logic [15:0] rdata_q = '0;
  logic [15:0] rdata_d;

  logic [7:0]  wword, rword;
  logic [15:0] wlane_mask, rlane_mask;
  logic [3:0]  wshift, rshift;
  logic        wr_en;
  logic [15:0] wr_bits, wr_data;

  sb_ram40_lane_sel #(.MODE(WRITE_MODE)) u_wsel (
    .addr_i      (waddr_i),
    .word_o      (wword),
    .lane_mask_o (wlane_mask),
    .shift_o     (wshift)
  );

  sb_ram40_lane_sel #(.MODE(READ_MODE)) u_rsel (
    .addr_i      (raddr_i),
    .word_o      (rword),
    .lane_mask_o (rlane_mask),
    .shift_o     (rshift)
  );

  // The bit mask only applies in 16-bit mode; narrower modes write exactly their lane.
  always_comb begin
    wr_en   = we_i && wclke_i;
    wr_bits = (WRITE_MODE == MODE_256X16) ? ~mask_i : wlane_mask;
    wr_data = wdata_i << wshift;
  end

  always_comb begin
    rdata_d = rdata_q;
    if (re_i && rclke_i) rdata_d = (mem_q[rword] & rlane_mask) >> rshift;
  end

  // Read samples mem_q before this edge's write lands, giving read-before-write.
  always_ff @(posedge clk_i) begin
    if (wr_en) mem_q[wword] <= (mem_q[wword] & ~wr_bits) | (wr_data & wr_bits);
    if (rst_i) rdata_q <= '0;
    else       rdata_q <= rdata_d;
  end

  assign rdata_o = rdata_q;

endmodule

// File: tb/tb_sb_ram40_4k.sv
// Scoreboard bench for sb_ram40_4k: three instances (W/R modes 0/0, 1/0, 3/2) vs a flat-bit model.
module tb_sb_ram40_4k;

  logic        clk = 1'b0;
  logic        rst   [3];
  logic [10:0] waddr [3];
  logic [10:0] raddr [3];
  logic [15:0] wdata [3];
  logic [15:0] mask  [3];
  logic        we    [3];
  logic        wclke [3];
  logic        re    [3];
  logic        rclke [3];
  logic [15:0] rdata [3];

  int unsigned wmode [3] = '{0, 1, 3};
  int unsigned rmode [3] = '{0, 0, 2};

  int total = 0;
  int bad   = 0;

  // Reference: the 4096 bits as one flat vector; aspect address a of width w covers bits [a*w +: w].
  bit          flat [3][4096];
  logic [15:0] last [3];

  logic [15:0] exp_q  [$];
  int          dut_q  [$];
  string       name_q [$];

  always #5 clk = ~clk;

  sb_ram40_4k #(.READ_MODE(0), .WRITE_MODE(0)) dut0 (
    .clk_i(clk), .rst_i(rst[0]), .waddr_i(waddr[0]), .raddr_i(raddr[0]), .wdata_i(wdata[0]),
    .mask_i(mask[0]), .we_i(we[0]), .wclke_i(wclke[0]), .re_i(re[0]), .rclke_i(rclke[0]),
    .rdata_o(rdata[0]));

  sb_ram40_4k #(.READ_MODE(0), .WRITE_MODE(1)) dut1 (
    .clk_i(clk), .rst_i(rst[1]), .waddr_i(waddr[1]), .raddr_i(raddr[1]), .wdata_i(wdata[1]),
    .mask_i(mask[1]), .we_i(we[1]), .wclke_i(wclke[1]), .re_i(re[1]), .rclke_i(rclke[1]),
    .rdata_o(rdata[1]));

  sb_ram40_4k #(.READ_MODE(2), .WRITE_MODE(3)) dut2 (
    .clk_i(clk), .rst_i(rst[2]), .waddr_i(waddr[2]), .raddr_i(raddr[2]), .wdata_i(wdata[2]),
    .mask_i(mask[2]), .we_i(we[2]), .wclke_i(wclke[2]), .re_i(re[2]), .rclke_i(rclke[2]),
    .rdata_o(rdata[2]));

  function automatic logic [15:0] model_read(input int d, input logic [10:0] a);
    int unsigned w, depth, base;
    logic [15:0] v;
    w     = 16 >> rmode[d];
    depth = 256 << rmode[d];
    base  = (int'(a) % depth) * w;
    v     = '0;
    for (int unsigned b = 0; b < w; b++) v[b] = flat[d][base + b];
    return v;
  endfunction

  function automatic void model_write(input int d, input logic [10:0] a,
                                      input logic [15:0] data, input logic [15:0] mk);
    int unsigned w, depth, base;
    w     = 16 >> wmode[d];
    depth = 256 << wmode[d];
    base  = (int'(a) % depth) * w;
    for (int unsigned b = 0; b < w; b++)
      if (wmode[d] != 0 || !mk[b]) flat[d][base + b] = data[b];
  endfunction

  task automatic step(input int d, input logic w_en, input logic w_ck, input logic r_en,
                      input logic r_ck, input logic rs, input logic [10:0] wa,
                      input logic [10:0] ra, input logic [15:0] wd, input logic [15:0] mk,
                      input string name);
    logic [15:0] e;
    @(negedge clk);
    for (int i = 0; i < 3; i++) begin
      we[i] = 1'b0; wclke[i] = 1'b0; re[i] = 1'b0; rclke[i] = 1'b0; rst[i] = 1'b0;
    end
    we[d] = w_en; wclke[d] = w_ck; re[d] = r_en; rclke[d] = r_ck; rst[d] = rs;
    waddr[d] = wa; raddr[d] = ra; wdata[d] = wd; mask[d] = mk;
    if (rs)                e = '0;
    else if (r_en && r_ck) e = model_read(d, ra);
    else                   e = last[d];
    last[d] = e;
    exp_q.push_back(e);
    dut_q.push_back(d);
    name_q.push_back(name);
    if (w_en && w_ck) model_write(d, wa, wd, mk);
    @(posedge clk);
  endtask

  task automatic wr(input int d, input logic [10:0] a, input logic [15:0] v, input logic [15:0] mk);
    step(d, 1, 1, 0, 0, 0, a, '0, v, mk, "write_hold");
  endtask

  task automatic rd(input int d, input logic [10:0] a, input string name);
    step(d, 0, 0, 1, 1, 0, '0, a, '0, '0, name);
  endtask

  // Monitor: every posedge with an outstanding expectation, compare 1 time unit later.
  always @(posedge clk) begin
    #1;
    if (exp_q.size() > 0) begin
      logic [15:0] e;
      int          d;
      string       n;
      e = exp_q.pop_front();
      d = dut_q.pop_front();
      n = name_q.pop_front();
      total++;
      if (rdata[d] !== e) begin
        bad++;
        $display("FAIL %s dut%0d: got %h want %h at %0t", n, d, rdata[d], e, $time);
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1);
  end

  initial begin
    for (int i = 0; i < 3; i++) begin
      rst[i] = 0; waddr[i] = '0; raddr[i] = '0; wdata[i] = '0; mask[i] = '0;
      we[i] = 0; wclke[i] = 0; re[i] = 0; rclke[i] = 0; last[i] = '0;
      for (int b = 0; b < 4096; b++) flat[i][b] = 1'b0;
    end
    #1;
    for (int i = 0; i < 3; i++) begin
      total++;
      if (rdata[i] !== 16'h0000) begin
        bad++;
        $display("FAIL power_up dut%0d: got %h want 0000", i, rdata[i]);
      end
    end

    // Directed: 256x16 instance
    wr(0, 11'h005, 16'hABCD, 16'h0000);
    rd(0, 11'h005, "basic_read");
    wr(0, 11'h003, 16'h1234, 16'h0000);
    wr(0, 11'h003, 16'hFFFF, 16'hFF00);
    rd(0, 11'h003, "bit_mask");
    wr(0, 11'h000, 16'h5555, 16'h0000);
    step(0, 1, 0, 0, 0, 0, 11'h000, '0, 16'h0000, 16'h0000, "wclke_off");
    rd(0, 11'h000, "wclke_off_read");
    step(0, 0, 0, 1, 0, 0, '0, 11'h003, '0, '0, "rclke_off_hold");
    wr(0, 11'h007, 16'h0001, 16'h0000);
    step(0, 1, 1, 1, 1, 0, 11'h007, 11'h007, 16'h0002, 16'h0000, "rdw_old");
    rd(0, 11'h007, "rdw_new");
    rd(0, 11'h705, "addr_high_ignored");
    step(0, 1, 1, 1, 1, 1, 11'h00A, 11'h005, 16'h7777, 16'h0000, "reset_over_read");
    rd(0, 11'h005, "after_reset");
    rd(0, 11'h00A, "write_in_reset");

    // Directed: byte writes, word reads
    wr(1, 11'h009, 16'hFF3C, 16'hFFFF);
    wr(1, 11'h008, 16'h00A5, 16'hFFFF);
    rd(1, 11'h004, "mixed_1_0");

    // Directed: pair writes, nibble reads
    wr(2, 11'h001, 16'h0003, 16'h0000);
    wr(2, 11'h000, 16'h0002, 16'h0000);
    rd(2, 11'h000, "mixed_3_2");

    // Randomized traffic on all three instances
    for (int d = 0; d < 3; d++) begin
      for (int n = 0; n < 200; n++) begin
        logic [10:0] wa, ra;
        wa = 11'($urandom_range(0, 31)) | 11'(32'($urandom) << (8 + wmode[d]));
        ra = 11'($urandom_range(0, 31)) | 11'(32'($urandom) << (8 + rmode[d]));
        step(d, 1'($urandom), 1'($urandom_range(0, 3) != 0), 1'($urandom),
             1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 15) == 0),
             wa, ra, 16'($urandom), 16'($urandom), "random");
      end
    end

    repeat (3) @(posedge clk);
    #2;
    total++;
    if (exp_q.size() != 0) begin
      bad++;
      $display("FAIL drain: got %0d pending want 0", exp_q.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
